// File: rtl/code_lock_fsm.sv
// Four-digit sequential code lock: synchronised switch/button front end,
// per-digit comparison, open/fail decision and timed lockout with alarm.
module code_lock_fsm #(
  parameter logic [15:0] CODE           = 16'h0000,
  parameter int          MAX_FAIL       = 3,
  parameter int          LOCKOUT_CYCLES = 100_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] sw,
  input  logic       enter_btn,
  input  logic       clear_btn,
  output logic       unlocked,
  output logic       alarm,
  output logic [1:0] digit_idx,
  output logic [1:0] fail_cnt
);

  localparam int CNT_W = $clog2(LOCKOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LOCKOUT_CYCLES - 1);
  localparam logic [1:0] FAIL_LIMIT = 2'(MAX_FAIL);

  typedef enum logic [1:0] {
    ST_ENTRY   = 2'd0,
    ST_OPEN    = 2'd1,
    ST_LOCKOUT = 2'd2
  } state_t;

  state_t           state, state_nx;
  logic [1:0]       idx, idx_nx;
  logic             err, err_nx;
  logic [1:0]       fail, fail_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;

  logic [3:0] sw_p0, sw_p1;
  logic       enter_p0, enter_p1, enter_p2;
  logic       clear_p0, clear_p1, clear_p2;
  logic       enter_p, clear_p;
  logic       eq;
  logic [3:0] digit_sel;
  logic [1:0] fail_inc;

  // Digit 0 lives in the top nibble so the code reads left to right.
  function automatic logic [3:0] code_digit(input logic [1:0] i);
    case (i)
      2'd0:    code_digit = CODE[15:12];
      2'd1:    code_digit = CODE[11:8];
      2'd2:    code_digit = CODE[7:4];
      default: code_digit = CODE[3:0];
    endcase
  endfunction

  // Stage p0/p1: two-flop synchronisers; p2: edge-detect history for buttons
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_p0    <= '0;
      sw_p1    <= '0;
      enter_p0 <= 1'b0;
      enter_p1 <= 1'b0;
      enter_p2 <= 1'b0;
      clear_p0 <= 1'b0;
      clear_p1 <= 1'b0;
      clear_p2 <= 1'b0;
    end else begin
      sw_p0    <= sw;
      sw_p1    <= sw_p0;
      enter_p0 <= enter_btn;
      enter_p1 <= enter_p0;
      enter_p2 <= enter_p1;
      clear_p0 <= clear_btn;
      clear_p1 <= clear_p0;
      clear_p2 <= clear_p1;
    end
  end

  assign enter_p = enter_p1 & ~enter_p2;
  assign clear_p = clear_p1 & ~clear_p2;

  assign digit_sel = code_digit(idx);

  fourBitEquality u_digit_eq (
    .A (sw_p1),
    .B (digit_sel),
    .Y (eq)
  );

  assign fail_inc = fail + 2'd1;

  // Control state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_ENTRY;
      idx   <= '0;
      err   <= 1'b0;
      fail  <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      idx   <= idx_nx;
      err   <= err_nx;
      fail  <= fail_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    err_nx   = err;
    fail_nx  = fail;
    cnt_nx   = cnt;
    case (state)
      ST_ENTRY: begin
        if (clear_p) begin
          idx_nx = '0;
          err_nx = 1'b0;
        end else if (enter_p) begin
          if (idx != 2'd3) begin
            err_nx = err | ~eq;
            idx_nx = idx + 2'd1;
          end else if (!err && eq) begin
            state_nx = ST_OPEN;
            idx_nx   = '0;
            err_nx   = 1'b0;
            fail_nx  = '0;
          end else begin
            // A bad attempt always consumes all four presses before counting.
            idx_nx  = '0;
            err_nx  = 1'b0;
            fail_nx = fail_inc;
            if (fail_inc == FAIL_LIMIT) begin
              state_nx = ST_LOCKOUT;
              cnt_nx   = CNT_LOAD;
            end
          end
        end
      end
      ST_OPEN: begin
        if (clear_p) begin
          state_nx = ST_ENTRY;
          idx_nx   = '0;
          err_nx   = 1'b0;
        end
      end
      ST_LOCKOUT: begin
        if (cnt == '0) begin
          state_nx = ST_ENTRY;
          fail_nx  = '0;
          idx_nx   = '0;
          err_nx   = 1'b0;
        end else begin
          cnt_nx = cnt - 1'b1;
        end
      end
      default: begin
        state_nx = ST_ENTRY;
        idx_nx   = '0;
        err_nx   = 1'b0;
        fail_nx  = '0;
        cnt_nx   = '0;
      end
    endcase
  end

  assign unlocked  = (state == ST_OPEN);
  assign alarm     = (state == ST_LOCKOUT);
  assign digit_idx = idx;
  assign fail_cnt  = fail;

endmodule

// Four-bit equality comparator used as the per-digit check.
module fourBitEquality (
  input  logic [3:0] A,
  input  logic [3:0] B,
  output logic       Y
);

  assign Y = (A == B);

endmodule
